// File: rtl/shift_arb2.sv
// shift_arb2: round-robin arbiter/sequencer sharing one 32-bit right shifter
// (logical/arithmetic) between two valid/ready clients. Each result is held
// for its owner under backpressure, and the bench-visible ops_done counts
// completed response handshakes, saturating at its maximum.
module shift_arb2 #(
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_in,
   input  logic [4:0]       req0_shamt,
   input  logic             req0_arith,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_in,
   input  logic [4:0]       req1_shamt,
   input  logic             req1_arith,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_out,
   output logic [TAG_W-1:0] rsp0_tag,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_out,
   output logic [TAG_W-1:0] rsp1_tag,
   output logic [CNT_W-1:0] ops_done
);

   localparam int unsigned DW = 32;
   localparam int unsigned SW = 5;

   typedef enum logic {IDLE, RESP} state_t;

   state_t           state;
   state_t           state_nx;
   logic             owner;
   logic             last_grant;
   logic [DW-1:0]    op_in;
   logic [SW-1:0]    op_shamt;
   logic             op_arith;
   logic [TAG_W-1:0] op_tag;
   logic [DW-1:0]    sr_out;
   logic             hs;
   logic             free;
   logic             grant0;
   logic             grant1;

   // sr32: right shifter fed only from the operand registers
   always_comb begin
      sr_out = op_in >> op_shamt;
      if (op_arith) begin
         sr_out = $unsigned($signed(op_in) >>> op_shamt);
      end
   end

   // Next state, grant and response routing
   always_comb begin
      state_nx   = state;
      hs         = 1'b0;
      free       = 1'b0;
      grant0     = 1'b0;
      grant1     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp0_out   = '0;
      rsp1_out   = '0;
      rsp0_tag   = '0;
      rsp1_tag   = '0;

      if (state == RESP) begin
         if (!owner) begin
            rsp0_valid = 1'b1;
            rsp0_out   = sr_out;
            rsp0_tag   = op_tag;
            hs         = rsp0_ready;
         end else begin
            rsp1_valid = 1'b1;
            rsp1_out   = sr_out;
            rsp1_tag   = op_tag;
            hs         = rsp1_ready;
         end
      end

      // Engine is free when idle or when the held result drains this cycle
      free = (state == IDLE) || hs;

      if (free && !rst) begin
         if (req0_valid && (!req1_valid || last_grant)) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end

      req0_ready = grant0;
      req1_ready = grant1;

      if (grant0 || grant1) begin
         state_nx = RESP;
      end else if (hs) begin
         state_nx = IDLE;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operand capture, grant history and completed-op counter
   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         op_in      <= '0;
         op_shamt   <= '0;
         op_arith   <= 1'b0;
         op_tag     <= '0;
         ops_done   <= '0;
      end else begin
         if (grant0) begin
            op_in      <= req0_in;
            op_shamt   <= req0_shamt;
            op_arith   <= req0_arith;
            op_tag     <= req0_tag;
            owner      <= 1'b0;
            last_grant <= 1'b0;
         end else if (grant1) begin
            op_in      <= req1_in;
            op_shamt   <= req1_shamt;
            op_arith   <= req1_arith;
            op_tag     <= req1_tag;
            owner      <= 1'b1;
            last_grant <= 1'b1;
         end
         if (hs && (ops_done != {CNT_W{1'b1}})) begin
            ops_done <= ops_done + CNT_W'(1);
         end
      end
   end

endmodule
